irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/define.sv | 20 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_ctrl_pkg;

    localparam int ID_W            = 5;
    localparam int CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } irq_state_e;

    // CLAIM read word: valid flag in bit 31, source id in the low bits.
    function automatic logic [31:0] claim_word(input logic valid, input logic [ID_W-1:0] id);
        logic [31:0] w;
        w = '0;
        if (valid) begin
            w[CLAIM_VALID_BIT] = 1'b1;
            w[ID_W-1:0]        = id;
        end
        return w;
    endfunction

endpackage

// File: rtl/define.sv
// Shared SoC address map and bus-width definitions.
// Timer and interrupt-controller register addresses live side by side here.
`ifndef SHARED_DEFINE_SV
`define SHARED_DEFINE_SV

`define MEM_ADDR_BUS     15:0
`define DATA_BUS         31:0

// Timer block
`define TIM_CTRL_ADDR    16'h0100
`define TIM_LOAD_ADDR    16'h0104
`define TIM_COUNT_ADDR   16'h0108
`define TIM_STATUS_ADDR  16'h010C

// Interrupt controller
`define IRQ_PEND_ADDR    16'h0200
`define IRQ_ENABLE_ADDR  16'h0204
`define IRQ_CLAIM_ADDR   16'h0208

`endif

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending-and-enabled vector.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_id = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: PEND / ENABLE / CLAIM registers and an
// IDLE -> REQ -> ACTIVE handshake with the core.
// Optional build macro IRQ_CTRL_LEVEL_EN: PEND follows the registered source
// lines (level mode); without it, rising edges latch PEND (edge mode).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     irq_src_i,
    input  logic [`MEM_ADDR_BUS] irq_r_addr_i,
    input  logic [`MEM_ADDR_BUS] irq_w_addr_i,
    input  logic [`DATA_BUS]     irq_data_i,
    input  logic                 irq_r_enable_i,
    input  logic                 irq_w_enable_i,
    output logic [`DATA_BUS]     irq_data_o,
    output logic                 irq_o
);

    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_enable;
    logic [ID_W-1:0]  r_claim_id;
    irq_state_e       r_state;
    irq_state_e       w_state_next;
    logic [`DATA_BUS] r_data;
    logic             r_irq;

    logic [N_SRC-1:0] w_pend_next;
    logic [N_SRC-1:0] w_active_req;
    logic             w_sel_valid;
    logic [ID_W-1:0]  w_sel_id;
    logic             w_wr_pend;
    logic             w_wr_enable;
    logic             w_wr_claim;
    logic             w_rd_claim;
    logic             w_claim_ok;
    logic             w_complete;
    logic             w_irq_next;
    logic [`DATA_BUS] w_rd_data;
    logic             w_unused_data;

    assign w_unused_data = ^irq_data_i;

    assign w_wr_pend   = irq_w_enable_i && (irq_w_addr_i == `IRQ_PEND_ADDR);
    assign w_wr_enable = irq_w_enable_i && (irq_w_addr_i == `IRQ_ENABLE_ADDR);
    assign w_wr_claim  = irq_w_enable_i && (irq_w_addr_i == `IRQ_CLAIM_ADDR);
    assign w_rd_claim  = irq_r_enable_i && (irq_r_addr_i == `IRQ_CLAIM_ADDR);

    assign w_active_req = r_pend & r_enable;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .i_req   (w_active_req),
        .o_valid (w_sel_valid),
        .o_id    (w_sel_id)
    );

    // A claim only takes effect while a request is being presented.
    assign w_claim_ok = w_rd_claim && (r_state == ST_REQ) && w_sel_valid;
    assign w_complete = w_wr_claim && (r_state == ST_ACTIVE)
                        && (irq_data_i[ID_W-1:0] == r_claim_id);

`ifdef IRQ_CTRL_LEVEL_EN
    genvar gi;
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign w_pend_next[gi] = irq_src_i[gi];
    end
`else
    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_src_prev;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_claim_clr;

    // Edge history: sample the lines, then keep the previous sample for compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_q    <= '0;
            r_src_prev <= '0;
        end else begin
            r_src_q    <= irq_src_i;
            r_src_prev <= r_src_q;
        end
    end

    assign w_edge = r_src_q & ~r_src_prev;
    assign w_w1c  = w_wr_pend ? irq_data_i[N_SRC-1:0] : '0;

    // A fresh edge beats both software clear paths on the same bit.
    genvar gi;
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign w_claim_clr[gi] = w_claim_ok && (w_sel_id == ID_W'(gi));
        assign w_pend_next[gi] = w_edge[gi]
                                 | (r_pend[gi] & ~w_w1c[gi] & ~w_claim_clr[gi]);
    end
`endif

    // Pending / enable / captured-id registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_enable   <= '0;
            r_claim_id <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_wr_enable) begin
                r_enable <= irq_data_i[N_SRC-1:0];
            end
            if (w_claim_ok) begin
                r_claim_id <= w_sel_id;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_sel_valid) w_state_next = ST_REQ;
            ST_REQ:    if (w_claim_ok) w_state_next = ST_ACTIVE;
                       else if (!w_sel_valid) w_state_next = ST_IDLE;
            ST_ACTIVE: if (w_complete) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // FSM output: request line tracks the REQ state, registered below.
    always_comb begin
        w_irq_next = (w_state_next == ST_REQ);
    end

    // Registered request line to the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_next;
        end
    end

    // Read-data mux; unmapped addresses read as zero.
    always_comb begin
        w_rd_data = '0;
        case (irq_r_addr_i)
            `IRQ_PEND_ADDR:   w_rd_data[N_SRC-1:0] = r_pend;
            `IRQ_ENABLE_ADDR: w_rd_data[N_SRC-1:0] = r_enable;
            `IRQ_CLAIM_ADDR:  w_rd_data = (r_state == ST_REQ)
                                          ? claim_word(w_sel_valid, w_sel_id) : '0;
            default:          w_rd_data = '0;
        endcase
    end

    // Read data is captured only on a read strobe and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (irq_r_enable_i) begin
            r_data <= w_rd_data;
        end
    end

    assign irq_data_o = r_data;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven bench for irq_ctrl with a read-data scoreboard.
module tb_irq_ctrl;

    localparam int N_SRC = 8;
`ifdef IRQ_CTRL_LEVEL_EN
    localparam logic LEVEL = 1'b1;
`else
    localparam logic LEVEL = 1'b0;
`endif

    localparam logic [15:0] AP = `IRQ_PEND_ADDR;
    localparam logic [15:0] AE = `IRQ_ENABLE_ADDR;
    localparam logic [15:0] AC = `IRQ_CLAIM_ADDR;
    localparam logic [15:0] AX = 16'h0300;

    logic             clk;
    logic             rst_n;
    logic [N_SRC-1:0] irq_src_i;
    logic [15:0]      irq_r_addr_i;
    logic [15:0]      irq_w_addr_i;
    logic [31:0]      irq_data_i;
    logic             irq_r_enable_i;
    logic             irq_w_enable_i;
    logic [31:0]      irq_data_o;
    logic             irq_o;

    irq_ctrl #(.N_SRC(N_SRC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src_i      (irq_src_i),
        .irq_r_addr_i   (irq_r_addr_i),
        .irq_w_addr_i   (irq_w_addr_i),
        .irq_data_i     (irq_data_i),
        .irq_r_enable_i (irq_r_enable_i),
        .irq_w_enable_i (irq_w_enable_i),
        .irq_data_o     (irq_data_o),
        .irq_o          (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [7:0]  src;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [7:0] src,
                       input logic [31:0] exp_rd, input logic exp_irq);
        vecs.push_back('{we, re, addr, wdata, src, exp_rd, exp_irq});
    endtask

    // One bus cycle: drive on the falling edge, compare just after the rising edge.
    task automatic do_cycle(input logic we, input logic re, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [7:0] src,
                            input logic [31:0] exp_rd, input logic exp_irq,
                            input string tag);
        logic [31:0] e;
        @(negedge clk);
        irq_w_enable_i = we;
        irq_w_addr_i   = addr;
        irq_data_i     = wdata;
        irq_r_enable_i = re;
        irq_r_addr_i   = addr;
        irq_src_i      = src;
        if (re) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        if (re) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_rd: scoreboard empty, got 0x%08h", tag, irq_data_o);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_rd"}, irq_data_o, e);
                last_rd = e;
            end
        end else begin
            check({tag, "_hold"}, irq_data_o, last_rd);
        end
        check({tag, "_irq"}, {31'b0, irq_o}, {31'b0, exp_irq});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        last_rd        = '0;
        rst_n          = 1'b0;
        irq_src_i      = '0;
        irq_r_addr_i   = '0;
        irq_w_addr_i   = '0;
        irq_data_i     = '0;
        irq_r_enable_i = 1'b0;
        irq_w_enable_i = 1'b0;

        #12;
        check("rst_irq",  {31'b0, irq_o}, 32'h0);
        check("rst_data", irq_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef IRQ_CTRL_LEVEL_EN
        // Single source pulse, claim, complete.
        add(1, 0, AE, 32'h01, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h01, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h01, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0000, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h00, 0);
        add(0, 1, AC, 32'h00, 8'h00, 32'h0, 0);
        add(1, 0, AC, 32'h00, 8'h00, 32'h0, 0);
        add(0, 1, AE, 32'h00, 8'h00, 32'h01, 0);
        // Simultaneous edges on 5 and 2: lowest first.
        add(1, 0, AE, 32'hFF, 8'h24, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0002, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h20, 0);
        add(1, 0, AC, 32'h02, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0005, 0);
        add(1, 0, AC, 32'h05, 8'h00, 32'h0, 0);
        // Mismatched completion keeps ACTIVE; matching one returns to IDLE.
        add(0, 0, AX, 32'h00, 8'h08, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0003, 0);
        add(1, 0, AC, 32'h05, 8'h02, 32'h0, 0);
        add(0, 1, AC, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(1, 0, AC, 32'h03, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0001, 0);
        add(1, 0, AC, 32'h01, 8'h00, 32'h0, 0);
        // W1C colliding with an edge: set wins; plain W1C drops REQ.
        add(0, 0, AX, 32'h00, 8'h04, 32'h0, 0);
        add(1, 0, AP, 32'h04, 8'h00, 32'h0, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h04, 1);
        add(1, 0, AP, 32'h04, 8'h00, 32'h0, 1);
        add(0, 1, AP, 32'h00, 8'h00, 32'h00, 0);
        // Claim-clear colliding with an edge on the claimed source.
        add(0, 0, AX, 32'h00, 8'h01, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h01, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0000, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h01, 0);
        add(1, 0, AC, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0000, 0);
        add(1, 0, AC, 32'h00, 8'h00, 32'h0, 0);
        // Unmapped accesses.
        add(1, 0, AX, 32'hFF, 8'h00, 32'h0, 0);
        add(0, 1, AE, 32'h00, 8'h00, 32'hFF, 0);
        add(0, 1, AX, 32'h00, 8'h00, 32'h0, 0);
        // Masked source becomes visible once enabled.
        add(1, 0, AE, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h80, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h80, 0);
        add(1, 0, AE, 32'h80, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h00, 32'h8000_0007, 0);
        add(1, 0, AC, 32'h07, 8'h00, 32'h0, 0);
`else
        // Level mode: PEND follows the line; W1C and claim-clear are ignored.
        add(1, 0, AE, 32'h02, 8'h02, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h02, 32'h0, 1);
        add(0, 1, AC, 32'h00, 8'h02, 32'h8000_0001, 0);
        add(0, 1, AP, 32'h00, 8'h02, 32'h02, 0);
        add(1, 0, AP, 32'h02, 8'h02, 32'h0, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h02, 0);
        add(0, 1, AP, 32'h00, 8'h00, 32'h00, 0);
        add(1, 0, AC, 32'h01, 8'h00, 32'h0, 0);
        add(0, 0, AX, 32'h00, 8'h00, 32'h0, 0);
`endif
        foreach (vecs[i]) begin
            do_cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].src,
                     vecs[i].exp_rd, vecs[i].exp_irq, $sformatf("v%0d", i));
        end

        // Asynchronous reset while a request is presented.
        do_cycle(1, 0, AE, 32'h80, 8'h80, 32'h0, 0, "r33_en");
        do_cycle(0, 0, AX, 32'h00, 8'h00, 32'h0, LEVEL, "r33_wait");
        do_cycle(0, 1, AE, 32'h00, 8'h00, 32'h80, 1, "r33_req");
        #2;
        rst_n = 1'b0;
        #1;
        check("r33_async_irq",  {31'b0, irq_o}, 32'h0);
        check("r33_async_data", irq_data_o, 32'h0);
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(0, 1, AP, 32'h00, 8'h00, 32'h0, 0, "r33_pend");
        do_cycle(0, 1, AE, 32'h00, 8'h00, 32'h0, 0, "r33_enable");
        do_cycle(0, 1, AC, 32'h00, 8'h00, 32'h0, 0, "r33_idle");

        // Source already high when reset releases counts as one edge.
        @(negedge clk);
        rst_n     = 1'b0;
        irq_src_i = 8'h01;
        last_rd   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1, 0, AE, 32'h01, 8'h01, 32'h0, 0, "r25_en");
        do_cycle(0, 0, AX, 32'h00, 8'h01, 32'h0, 1, "r25_req");
        do_cycle(0, 1, AC, 32'h00, 8'h01, 32'h8000_0000, 0, "r25_claim");
        do_cycle(0, 1, AP, 32'h00, 8'h01, {31'b0, LEVEL}, 0, "r25_pend");
        do_cycle(1, 0, AC, 32'h00, 8'h01, 32'h0, 0, "r25_done");
        do_cycle(0, 0, AX, 32'h00, 8'h01, 32'h0, LEVEL, "r25_quiet");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
